// File: rtl/sim_ram_arbiter.sv
// N-channel round-robin bridge from core memory request ports onto one RAMHelper-style port,
// with base-address translation, byte-to-bit mask expansion, range check and fixed latency.
module sim_ram_arbiter #(
    parameter int unsigned          NUM_CH    = 2,
    parameter int unsigned          ADDR_W    = 64,
    parameter int unsigned          DATA_W    = 64,
    parameter int unsigned          IDX_W     = 16,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = 'h8000_0000,
    parameter int unsigned          LATENCY   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req_valid_i,
    output logic [NUM_CH-1:0]          req_ready_o,
    input  logic [NUM_CH-1:0]          req_wen_i,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata_i,
    input  logic [NUM_CH*DATA_W/8-1:0] req_wmask_i,
    output logic [NUM_CH-1:0]          resp_valid_o,
    output logic [NUM_CH-1:0]          resp_err_o,
    output logic [NUM_CH*DATA_W-1:0]   resp_data_o,
    output logic                       mem_en_o,
    output logic [IDX_W-1:0]           mem_idx_o,
    output logic                       mem_wen_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic [DATA_W-1:0]          mem_wmask_o,
    input  logic [DATA_W-1:0]          mem_rdata_i
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned SHIFT = $clog2(BYTES);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CH_W-1:0]            owner_q, owner_d;
    logic [CH_W-1:0]            last_q, last_d;
    logic                       err_q, err_d;
    logic [DATA_W-1:0]          pend_q, pend_d;
    logic [NUM_CH*DATA_W-1:0]   hold_q;

    logic                       gnt_found;
    logic [CH_W-1:0]            gnt_idx;
    int unsigned                cand;
    logic                       resp_fire;
    logic                       arb_en;
    logic                       accept;

    logic [ADDR_W-1:0]          g_addr;
    logic [DATA_W-1:0]          g_wdata;
    logic [BYTES-1:0]           g_wmask;
    logic                       g_wen;
    logic [ADDR_W:0]            diff;
    logic [ADDR_W-1:0]          idx_full;
    logic                       in_range;

    // First valid channel searched from the one after the last grant.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cand = (int'(last_q) + 1 + i) % NUM_CH;
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(cand);
            end
        end
    end

    always_comb begin
        g_addr  = req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
        g_wdata = req_wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
        g_wmask = req_wmask_i[int'(gnt_idx)*BYTES +: BYTES];
        g_wen   = req_wen_i[gnt_idx];
        // Borrow out of the extended subtraction flags addresses below the base.
        diff     = {1'b0, g_addr} - {1'b0, BASE_ADDR};
        idx_full = diff[ADDR_W-1:0] >> SHIFT;
        in_range = !diff[ADDR_W] && ((idx_full >> IDX_W) == '0);
    end

    always_comb begin
        resp_fire = !reset && (state_q == StWait) && (cnt_q == '0);
        arb_en    = !reset && ((state_q == StIdle) || resp_fire);
        accept    = arb_en && gnt_found;

        req_ready_o = '0;
        if (accept) begin
            req_ready_o[gnt_idx] = 1'b1;
        end

        mem_en_o    = 1'b0;
        mem_idx_o   = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (accept && in_range) begin
            mem_en_o    = 1'b1;
            mem_idx_o   = idx_full[IDX_W-1:0];
            mem_wen_o   = g_wen;
            mem_wdata_o = g_wdata;
            for (int b = 0; b < int'(BYTES); b++) begin
                mem_wmask_o[8*b +: 8] = {8{g_wmask[b]}};
            end
        end

        resp_valid_o = '0;
        resp_err_o   = '0;
        resp_data_o  = hold_q;
        if (resp_fire) begin
            resp_valid_o[owner_q]                    = 1'b1;
            resp_err_o[owner_q]                      = err_q;
            resp_data_o[int'(owner_q)*DATA_W +: DATA_W] = pend_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q;
        pend_d  = pend_q;
        if (accept) begin
            state_d = StWait;
            cnt_d   = CNT_W'(LATENCY - 1);
            owner_d = gnt_idx;
            last_d  = gnt_idx;
            err_d   = !in_range;
            pend_d  = (in_range && !g_wen) ? mem_rdata_i : '0;
        end else if (resp_fire) begin
            state_d = StIdle;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            err_q   <= 1'b0;
            pend_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            hold_q  <= resp_data_o;
        end
    end

endmodule
